// File: rtl/riscv_constants.sv
// Shared execute-stage encodings: ALU/divider operation select and divider FSM states.
package riscv_constants;

    typedef enum logic [4:0] {
        ALU_ADD  = 5'd0,
        ALU_SUB  = 5'd1,
        ALU_SLL  = 5'd2,
        ALU_SLT  = 5'd3,
        ALU_SLTU = 5'd4,
        ALU_XOR  = 5'd5,
        ALU_SRL  = 5'd6,
        ALU_SRA  = 5'd7,
        ALU_OR   = 5'd8,
        ALU_AND  = 5'd9,
        ALU_DIV  = 5'd10,
        ALU_DIVU = 5'd11,
        ALU_REM  = 5'd12,
        ALU_REMU = 5'd13
    } exec_fun_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } div_state_e;

    function automatic logic is_div_op(input exec_fun_e f);
        return f inside {ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU};
    endfunction

endpackage

// File: rtl/riscv_div_unit.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU: one quotient bit per cycle,
// with divide-by-zero and signed-overflow results produced without iterating.
module riscv_div_unit
    import riscv_constants::*;
#(
    parameter int WORD_LENGTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  exec_fun_e              exec_fun,
    input  logic                   start,
    input  logic                   kill,
    input  logic [WORD_LENGTH-1:0] data1,
    input  logic [WORD_LENGTH-1:0] data2,
    output logic                   busy,
    output logic                   result_valid,
    output logic [WORD_LENGTH-1:0] result,
    output logic [1:0]             dbg_state
);

    localparam int CW = $clog2(WORD_LENGTH);
    localparam logic [CW-1:0] LAST_CNT = CW'(WORD_LENGTH - 1);
    localparam logic [WORD_LENGTH-1:0] MIN_INT  = {1'b1, {(WORD_LENGTH-1){1'b0}}};
    localparam logic [WORD_LENGTH-1:0] ALL_ONES = '1;

    div_state_e             state_q, state_d;
    logic                   rem_op_q, rem_op_d;
    logic                   signed_q, signed_d;
    logic                   quo_neg_q, quo_neg_d;
    logic                   rem_neg_q, rem_neg_d;
    logic [WORD_LENGTH-1:0] dvd_q, dvd_d;
    logic [WORD_LENGTH-1:0] dsr_q, dsr_d;
    logic [WORD_LENGTH-1:0] rem_q, rem_d;
    logic [CW-1:0]          count_q, count_d;
    logic [WORD_LENGTH-1:0] result_q, result_d;

    logic                   op_signed;
    logic                   sub_ok;
    logic [WORD_LENGTH:0]   rem_sh;
    logic [WORD_LENGTH:0]   rem_diff;
    logic [WORD_LENGTH-1:0] rem_next, quo_next, rem_fix, quo_fix;

    always_comb begin
        state_d   = state_q;
        rem_op_d  = rem_op_q;
        signed_d  = signed_q;
        quo_neg_d = quo_neg_q;
        rem_neg_d = rem_neg_q;
        dvd_d     = dvd_q;
        dsr_d     = dsr_q;
        rem_d     = rem_q;
        count_d   = count_q;
        result_d  = result_q;
        op_signed = 1'b0;

        // The dividend register doubles as the quotient: each step shifts a
        // dividend bit out of the top and a quotient bit in at the bottom.
        rem_sh   = {rem_q, dvd_q[WORD_LENGTH-1]};
        sub_ok   = rem_sh >= {1'b0, dsr_q};
        rem_diff = rem_sh - {1'b0, dsr_q};
        rem_next = sub_ok ? rem_diff[WORD_LENGTH-1:0] : rem_sh[WORD_LENGTH-1:0];
        quo_next = {dvd_q[WORD_LENGTH-2:0], sub_ok};
        quo_fix  = (signed_q && quo_neg_q) ? -quo_next : quo_next;
        rem_fix  = (signed_q && rem_neg_q) ? -rem_next : rem_next;

        case (state_q)
            IDLE: begin
                if (start && !kill && is_div_op(exec_fun)) begin
                    op_signed = exec_fun inside {ALU_DIV, ALU_REM};
                    rem_op_d  = exec_fun inside {ALU_REM, ALU_REMU};
                    signed_d  = op_signed;
                    quo_neg_d = data1[WORD_LENGTH-1] ^ data2[WORD_LENGTH-1];
                    rem_neg_d = data1[WORD_LENGTH-1];
                    if (data2 == '0) begin
                        result_d = rem_op_d ? data1 : ALL_ONES;
                        state_d  = DONE;
                    end else if (op_signed && data1 == MIN_INT && data2 == ALL_ONES) begin
                        result_d = rem_op_d ? '0 : MIN_INT;
                        state_d  = DONE;
                    end else begin
                        dvd_d   = (op_signed && data1[WORD_LENGTH-1]) ? -data1 : data1;
                        dsr_d   = (op_signed && data2[WORD_LENGTH-1]) ? -data2 : data2;
                        rem_d   = '0;
                        count_d = LAST_CNT;
                        state_d = CALC;
                    end
                end
            end
            CALC: begin
                if (kill) begin
                    state_d = IDLE;
                end else begin
                    rem_d   = rem_next;
                    dvd_d   = quo_next;
                    count_d = count_q - 1'b1;
                    if (count_q == '0) begin
                        result_d = rem_op_q ? rem_fix : quo_fix;
                        state_d  = DONE;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rem_op_q  <= 1'b0;
            signed_q  <= 1'b0;
            quo_neg_q <= 1'b0;
            rem_neg_q <= 1'b0;
            dvd_q     <= '0;
            dsr_q     <= '0;
            rem_q     <= '0;
            count_q   <= '0;
            result_q  <= '0;
        end else begin
            state_q   <= state_d;
            rem_op_q  <= rem_op_d;
            signed_q  <= signed_d;
            quo_neg_q <= quo_neg_d;
            rem_neg_q <= rem_neg_d;
            dvd_q     <= dvd_d;
            dsr_q     <= dsr_d;
            rem_q     <= rem_d;
            count_q   <= count_d;
            result_q  <= result_d;
        end
    end

    assign busy         = (state_q != IDLE);
    assign result_valid = (state_q == DONE) && !kill;
    assign result       = result_q;
    assign dbg_state    = state_q;

endmodule

// File: tb/tb_riscv_div_unit.sv
// Directed bench for riscv_div_unit: latency, signed/unsigned results, special cases, kill and reset.
module tb_riscv_div_unit;
    import riscv_constants::*;

    logic        clk = 1'b0;
    logic        rst;
    exec_fun_e   exec_fun;
    logic        start;
    logic        kill;
    logic [31:0] data1;
    logic [31:0] data2;
    logic        busy;
    logic        result_valid;
    logic [31:0] result;
    logic [1:0]  dbg_state;

    int vectors = 0;
    int miscompares = 0;

    riscv_div_unit #(.WORD_LENGTH(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .exec_fun     (exec_fun),
        .start        (start),
        .kill         (kill),
        .data1        (data1),
        .data2        (data2),
        .busy         (busy),
        .result_valid (result_valid),
        .result       (result),
        .dbg_state    (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called #1 after a clock edge; start is sampled at the next edge (edge 0),
    // and the cycle following edge 0 is counted as cycle 1.
    task automatic do_op(input exec_fun_e fun, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input int stray_at,
                         input string tag);
        int cyc;
        int busy_cnt;
        bit seen;
        exec_fun = fun;
        data1    = a;
        data2    = b;
        start    = 1'b1;
        @(posedge clk); #1;
        start    = 1'b0;
        exec_fun = ALU_ADD;
        data1    = 32'hDEAD_BEEF;
        data2    = 32'h0;
        cyc = 1; busy_cnt = 0; seen = 1'b0;
        while (cyc <= 40 && !seen) begin
            if (busy) busy_cnt++;
            if (result_valid) begin
                seen = 1'b1;
            end else begin
                if (cyc == stray_at) begin
                    start = 1'b1; exec_fun = ALU_DIVU; data1 = 32'd100; data2 = 32'd7;
                end
                @(posedge clk); #1;
                start    = 1'b0;
                exec_fun = ALU_ADD;
                cyc++;
            end
        end
        check({tag, " valid"}, {31'b0, seen}, 32'd1);
        check({tag, " latency"}, cyc, exp_lat);
        check({tag, " busy_cycles"}, busy_cnt, exp_lat);
        check({tag, " result"}, result, exp_res);
        @(posedge clk); #1;
        check({tag, " idle_after"}, {30'b0, busy, result_valid}, 32'd0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; kill = 1'b0; exec_fun = ALU_ADD;
        data1 = '0; data2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset busy", {31'b0, busy}, 32'd0);
        check("reset valid", {31'b0, result_valid}, 32'd0);
        check("reset result", result, 32'd0);
        check("reset state", {30'b0, dbg_state}, 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        do_op(ALU_DIVU, 32'd100, 32'd7, 32'd14, 33, 0, "divu 100/7");
        do_op(ALU_REMU, 32'd100, 32'd7, 32'd2, 33, 0, "remu 100/7");
        do_op(ALU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 0, "div -7/2");
        do_op(ALU_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 0, "rem -7/2");
        do_op(ALU_REM, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 33, 0, "rem -7/-2");
        do_op(ALU_DIV, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'd3, 33, 0, "div -7/-2");
        do_op(ALU_DIV, 32'd100, 32'hFFFF_FFF9, 32'hFFFF_FFF2, 33, 0, "div 100/-7");
        do_op(ALU_REM, 32'd100, 32'hFFFF_FFF9, 32'd2, 33, 0, "rem 100/-7");
        do_op(ALU_DIVU, 32'd5, 32'd0, 32'hFFFF_FFFF, 1, 0, "divu 5/0");
        do_op(ALU_REM, 32'd5, 32'd0, 32'd5, 1, 0, "rem 5/0");
        do_op(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 0, "div ovf");
        do_op(ALU_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1, 0, "rem ovf");
        do_op(ALU_DIVU, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF, 33, 0, "divu max/16");
        do_op(ALU_REMU, 32'hFFFF_FFFF, 32'h10, 32'h0000_000F, 33, 0, "remu max/16");

        // Kill at CALC cycle 10.
        begin
            int vcnt;
            exec_fun = ALU_DIVU; data1 = 32'd1000; data2 = 32'd3; start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0; exec_fun = ALU_ADD;
            repeat (9) @(posedge clk);
            #1;
            check("kill pre busy", {31'b0, busy}, 32'd1);
            kill = 1'b1;
            check("kill valid suppressed", {31'b0, result_valid}, 32'd0);
            @(posedge clk); #1;
            kill = 1'b0;
            check("kill busy after", {31'b0, busy}, 32'd0);
            vcnt = 0;
            repeat (30) begin
                if (result_valid || busy) vcnt++;
                @(posedge clk); #1;
            end
            check("kill no late valid", vcnt, 32'd0);
        end

        do_op(ALU_DIVU, 32'd9, 32'd3, 32'd3, 33, 5, "divu 9/3 stray start");

        // Non-div op and kill+start in IDLE are both ignored.
        exec_fun = ALU_ADD; data1 = 32'd10; data2 = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("non-div start ignored", {31'b0, busy}, 32'd0);
        exec_fun = ALU_DIVU; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0; exec_fun = ALU_ADD;
        check("kill beats start", {31'b0, busy}, 32'd0);

        // Reset mid-CALC clears the held result of the previous op.
        exec_fun = ALU_DIVU; data1 = 32'd100; data2 = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; exec_fun = ALU_ADD;
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst busy", {31'b0, busy}, 32'd0);
        check("midrst valid", {31'b0, result_valid}, 32'd0);
        check("midrst result", result, 32'd0);
        check("midrst state", {30'b0, dbg_state}, 32'd0);

        do_op(ALU_DIVU, 32'd50, 32'd7, 32'd7, 33, 0, "divu after rst");
        do_op(ALU_REMU, 32'd50, 32'd7, 32'd1, 33, 0, "remu back2back");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
